enc8x3_latched: RTL and testbench
=================================

# enc8x3_latched

Registered 8-to-3 priority encoder with request latching and a Valid/Ack handshake. It is the inverse of the lab's 3-to-8 decoder: eight request lines in, a 3-bit index out (X = MSB, Z = LSB, the same bit order the decoder consumes). Rising edges on D0..D7 are captured into a pending register. The block presents one pending index at a time and holds it until the consumer acknowledges it. It sits between raw event sources (buttons, decoder-driven strobes) and a consumer that services one event per handshake.

## Interface
Parameters: none.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset; one clock domain.
- D  input  8  request lines D[7:0]; synchronous to Clk.
- Ack  input  1  consumer acknowledge; level-sampled on the Clk edge.
- X, Y, Z  output  1 each  encoded index of the presented request; X is the MSB.
- Valid  output  1  the X/Y/Z code is meaningful.
- Pend  output  8  current pending register, for observation.
- Ovf  output  1  sticky overrun flag.

## Operation
- Edge capture:
  - D_q holds D delayed by one Clk.
  - A new pending bit is D & ~D_q.
  - Levels held high raise only one request.
- Pending update each edge: Pend <= (Pend & ~clr) | rise.
  - clr is the one-hot bit of the index being acknowledged.
  - Set wins over clear on the same bit in the same cycle.
- FSM states: IDLE and PRESENT.
- IDLE:
  - If Pend != 0, latch the selected index into X/Y/Z, set Valid = 1, go to PRESENT.
  - Otherwise stay in IDLE with Valid = 0.
- PRESENT:
  - X/Y/Z and Valid are held stable.
  - When Ack = 1 at an edge: clear that index's Pend bit, set Valid = 0, go to IDLE.
- Selection is fixed priority: highest-numbered pending bit wins (D7 highest).
- Ack while Valid = 0 is ignored.
- Ovf:
  - Set when a rising edge arrives on a bit that is already pending and is not being cleared that cycle.
  - Cleared only by reset.
- Reset:
  - Values: Pend = 0, D_q = 0, X/Y/Z = 000, Valid = 0, Ovf = 0, FSM = IDLE.
  - Asserting Rst_n mid-handshake drops Valid immediately (asynchronously). The presented request is lost.
  - A D line that is high during reset deassertion counts as a rising edge on the first edge after release.

## Timing
- D rising before edge k: the Pend bit is set at edge k, Valid = 1 after edge k+1. Request-to-Valid latency is 2 edges.
- Ack high at edge m while Valid = 1: Valid = 0 after edge m. The next Valid is earliest after edge m+1, so there is at least one idle cycle between grants.
- X/Y/Z change only on the IDLE-to-PRESENT transition.
- X/Y/Z hold their last value while Valid = 0.
- Throughput: at most one request per 2 cycles. An Ack held permanently high yields alternating Valid.

## Configuration
- Macro ENC_ROUND_ROBIN_EN.
  - Defined: selection is rotating priority. The search starts one bit above the last granted index, wrapping 7 to 0. After reset the last-granted pointer is 7, so bit 0 is searched first.
  - Undefined: fixed priority, D7 highest.
- Edge capture, handshake, timing and Ovf are identical in both builds.

## Test plan
- Reset:
  - Stimulus: Rst_n = 0 with D = 8'hFF, then release.
  - Response: during reset all outputs are 0. After release Pend = FF on the first edge and Valid = 1 with XYZ = 111 one edge later.
- Single request:
  - Stimulus: D[5] pulses high for 1 cycle, Ack is asserted 3 cycles after Valid.
  - Response: XYZ = 101 and Valid held through the wait. Valid falls the edge after Ack, and Pend = 00.
- Simultaneous requests:
  - Stimulus: D[2] and D[6] rise together, Ack is given once per grant.
  - Response, fixed build: grants 110 then 010.
  - Response, ENC_ROUND_ROBIN_EN build: grants 010 then 110.
- Set/clear collision:
  - Stimulus: bit 3 is presented, and D[3] re-rises on the same edge that Ack clears it.
  - Response: Pend[3] stays 1, a second grant with XYZ = 011 follows, Ovf = 0.
- Overrun:
  - Stimulus: D[1] pulses twice with no Ack in between.
  - Response: Ovf = 1 and stays 1 after service. Only one grant with XYZ = 001 occurs.
- Mid-handshake reset:
  - Stimulus: Rst_n is asserted while Valid = 1.
  - Response: Valid = 0 immediately, Pend = 00. No grant after release when D is held at 0.

Source files
------------

// File: rtl/enc8x3_latched.sv
// enc8x3_latched
//   Registered 8-to-3 priority encoder with rising-edge request latching and a
//   Valid/Ack handshake. Rising edges on D are captured into a pending register;
//   one pending index is presented on X/Y/Z (X = MSB) until acknowledged.
//
// Ports:
//   Clk    in   system clock, rising edge
//   Rst_n  in   asynchronous active-low reset
//   D      in   [7:0] request lines
//   Ack    in   consumer acknowledge, level-sampled
//   X,Y,Z  out  encoded index of the presented request (X = MSB)
//   Valid  out  X/Y/Z are meaningful
//   Pend   out  [7:0] pending register
//   Ovf    out  sticky overrun flag (cleared only by reset)
//
// Configuration:
//   ENC_ROUND_ROBIN_EN  defined: rotating priority, search starts one above the
//                       last granted index (pointer resets to 7).
//                       undefined: fixed priority, D[7] highest.

module enc8x3_latched (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] D,
  input  logic       Ack,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       Valid,
  output logic [7:0] Pend,
  output logic       Ovf
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] d_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [2:0] idx_q, idx_d;
  logic [2:0] sel;
  logic       grant;
  logic       ovf_q;

  assign rise   = D & ~d_q;
  // Set wins over clear when a bit re-rises on the edge it is acknowledged.
  assign pend_d = (pend_q & ~clr) | rise;

`ifdef ENC_ROUND_ROBIN_EN
  logic [2:0] last_q;

  // Walk candidates from farthest to nearest so the nearest pending bit above
  // last_q overwrites; offset 8 wraps to last_q itself (lowest priority).
  always_comb begin
    logic [2:0] cand;
    sel  = '0;
    cand = '0;
    for (int unsigned k = 8; k > 0; k--) begin
      cand = last_q + 3'(k);
      if (pend_q[cand]) sel = cand;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     last_q <= 3'd7;
    else if (grant) last_q <= sel;
  end
`else
  // Ascending scan: the highest pending bit is the last to assign.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = '0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          idx_d   = sel;
          grant   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (Ack) begin
          clr     = 8'b0000_0001 << idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      d_q    <= '0;
      pend_q <= '0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      d_q    <= D;
      pend_q <= pend_d;
      idx_q  <= idx_d;
      ovf_q  <= ovf_q | (|(rise & pend_q & ~clr));
    end
  end

  assign {X, Y, Z} = idx_q;
  assign Valid     = (state_q == PRESENT);
  assign Pend      = pend_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_enc8x3_latched.sv
module tb_enc8x3_latched;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] D;
  logic       Ack;
  logic       X, Y, Z;
  logic       Valid;
  logic [7:0] Pend;
  logic       Ovf;

  int checks = 0;
  int errors = 0;

  enc8x3_latched dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .D     (D),
    .Ack   (Ack),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .Valid (Valid),
    .Pend  (Pend),
    .Ovf   (Ovf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] xyz();
    return {5'b0, X, Y, Z};
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

`ifdef ENC_ROUND_ROBIN_EN
  localparam logic [7:0] FIRST_ALL  = 8'd0;
  localparam logic [7:0] SIM_FIRST  = 8'd2;
  localparam logic [7:0] SIM_SECOND = 8'd6;
  localparam logic [7:0] SIM_LEFT   = 8'h40;
`else
  localparam logic [7:0] FIRST_ALL  = 8'd7;
  localparam logic [7:0] SIM_FIRST  = 8'd6;
  localparam logic [7:0] SIM_SECOND = 8'd2;
  localparam logic [7:0] SIM_LEFT   = 8'h04;
`endif

  initial begin
    // Reset with all request lines high
    Rst_n = 1'b0;
    D     = 8'hFF;
    Ack   = 1'b0;
    step();
    step();
    chk("rst_valid", {7'b0, Valid}, 8'h00);
    chk("rst_xyz",   xyz(),         8'h00);
    chk("rst_pend",  Pend,          8'h00);
    chk("rst_ovf",   {7'b0, Ovf},   8'h00);
    Rst_n = 1'b1;
    step();
    chk("rel_pend",  Pend,          8'hFF);
    chk("rel_valid0",{7'b0, Valid}, 8'h00);
    D = 8'h00;
    step();
    chk("rel_valid1",{7'b0, Valid}, 8'h01);
    chk("rel_xyz",   xyz(),         FIRST_ALL);

    // Mid-handshake reset: Valid drops asynchronously
    Rst_n = 1'b0;
    #1;
    chk("mid_valid", {7'b0, Valid}, 8'h00);
    chk("mid_pend",  Pend,          8'h00);
    chk("mid_xyz",   xyz(),         8'h00);
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_nogrant", {7'b0, Valid}, 8'h00);
    end

    // Single request on D[5], Ack three cycles after Valid
    D = 8'h20;
    step();
    D = 8'h00;
    chk("one_pend",   Pend,          8'h20);
    chk("one_valid0", {7'b0, Valid}, 8'h00);
    step();
    chk("one_valid1", {7'b0, Valid}, 8'h01);
    chk("one_xyz",    xyz(),         8'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("one_hold_v", {7'b0, Valid}, 8'h01);
      chk("one_hold_x", xyz(),         8'd5);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("one_ackv",   {7'b0, Valid}, 8'h00);
    chk("one_ackp",   Pend,          8'h00);
    chk("one_xyzkeep",xyz(),         8'd5);

    // Simultaneous D[2] and D[6], from a fresh reset
    do_reset();
    D = 8'h44;
    step();
    D = 8'h00;
    chk("sim_pend",   Pend,          8'h44);
    step();
    chk("sim_v1",     {7'b0, Valid}, 8'h01);
    chk("sim_x1",     xyz(),         SIM_FIRST);
    Ack = 1'b1;
    step();
    chk("sim_gap",    {7'b0, Valid}, 8'h00);
    chk("sim_left",   Pend,          SIM_LEFT);
    step();
    chk("sim_v2",     {7'b0, Valid}, 8'h01);
    chk("sim_x2",     xyz(),         SIM_SECOND);
    step();
    Ack = 1'b0;
    chk("sim_done_v", {7'b0, Valid}, 8'h00);
    chk("sim_done_p", Pend,          8'h00);

    // Set/clear collision on bit 3
    D = 8'h08;
    step();
    D = 8'h00;
    step();
    chk("col_v1",     {7'b0, Valid}, 8'h01);
    chk("col_x1",     xyz(),         8'd3);
    D   = 8'h08;
    Ack = 1'b1;
    step();
    D   = 8'h00;
    Ack = 1'b0;
    chk("col_pend",   Pend,          8'h08);
    chk("col_ovf",    {7'b0, Ovf},   8'h00);
    chk("col_gap",    {7'b0, Valid}, 8'h00);
    step();
    chk("col_v2",     {7'b0, Valid}, 8'h01);
    chk("col_x2",     xyz(),         8'd3);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("col_done",   Pend,          8'h00);
    chk("col_ovf2",   {7'b0, Ovf},   8'h00);

    // Overrun: D[1] pulses twice without Ack
    D = 8'h02;
    step();
    D = 8'h00;
    step();
    chk("ovr_v1",     {7'b0, Valid}, 8'h01);
    chk("ovr_x1",     xyz(),         8'd1);
    chk("ovr_ovf0",   {7'b0, Ovf},   8'h00);
    D = 8'h02;
    step();
    D = 8'h00;
    chk("ovr_ovf1",   {7'b0, Ovf},   8'h01);
    chk("ovr_pend",   Pend,          8'h02);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("ovr_ackv",   {7'b0, Valid}, 8'h00);
    chk("ovr_ackp",   Pend,          8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovr_nogrant", {7'b0, Valid}, 8'h00);
      chk("ovr_sticky",  {7'b0, Ovf},   8'h01);
    end

    // Ack with nothing presented is ignored
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("idle_ack_v", {7'b0, Valid}, 8'h00);
    chk("idle_ack_p", Pend,          8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
